// File: rtl/up_link_pkg.sv
// Shared definitions for the uplink TX arbiter and the RX-side distributor.
package up_link_pkg;
  localparam int unsigned C_AXIS_DW       = 64;
  localparam int unsigned C_AXIS_KW       = 8;
  localparam int unsigned C_MAX_BEATS_DEF = 1200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter_pick #(
  parameter int unsigned P_N     = 4,
  parameter int unsigned P_PTR_W = (P_N > 1) ? $clog2(P_N) : 1
) (
  input  logic [P_N-1:0]     req,
  input  logic [P_PTR_W-1:0] ptr,
  output logic [P_N-1:0]     gnt,
  output logic               vld
);
  int unsigned idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int unsigned i = 0; i < P_N; i++) begin
      idx = (32'(ptr) + i) % P_N;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/up_link_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one 10G MAC TX AXI-Stream channel;
// holds a grant per packet, waits for link up, and truncates runaway packets.
module up_link_tx_arbiter
  import up_link_pkg::*;
#(
  parameter int unsigned P_REQ_NUM   = 4,
  parameter int unsigned P_MAX_BEATS = C_MAX_BEATS_DEF,
  parameter int unsigned P_CNT_W     = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_stat_rx_status,
  input  logic [P_REQ_NUM-1:0]           i_s_axis_tvalid,
  input  logic [P_REQ_NUM*C_AXIS_DW-1:0] i_s_axis_tdata,
  input  logic [P_REQ_NUM*C_AXIS_KW-1:0] i_s_axis_tkeep,
  input  logic [P_REQ_NUM-1:0]           i_s_axis_tlast,
  input  logic [P_REQ_NUM-1:0]           i_s_axis_tuser,
  output logic [P_REQ_NUM-1:0]           o_s_axis_tready,
  output logic                           o_m_axis_tvalid,
  output logic [C_AXIS_DW-1:0]           o_m_axis_tdata,
  output logic [C_AXIS_KW-1:0]           o_m_axis_tkeep,
  output logic                           o_m_axis_tlast,
  output logic                           o_m_axis_tuser,
  input  logic                           i_m_axis_tready,
  output logic [P_REQ_NUM-1:0]           o_grant,
  output logic [P_CNT_W-1:0]             o_pkt_cnt,
  output logic [P_CNT_W-1:0]             o_trunc_cnt
);
  localparam int unsigned C_PTR_W  = $clog2(P_REQ_NUM);
  localparam int unsigned C_BEAT_W = $clog2(P_MAX_BEATS);
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(P_MAX_BEATS - 1);
  localparam logic [C_PTR_W-1:0]  C_LAST_REQ  = C_PTR_W'(P_REQ_NUM - 1);

  state_e                state, state_nxt;
  logic [P_REQ_NUM-1:0]  grant;
  logic [C_PTR_W-1:0]    g_idx, rr_ptr, next_ptr, pick_idx;
  logic [C_BEAT_W-1:0]   beat_cnt;
  logic [P_REQ_NUM-1:0]  pick_gnt;
  logic                  pick_vld;
  logic                  sel_valid, sel_last, sel_user;
  logic [C_AXIS_DW-1:0]  sel_data;
  logic [C_AXIS_KW-1:0]  sel_keep;
  logic                  at_limit, trunc, eff_last, accept, start;

  rr_arbiter_pick #(.P_N(P_REQ_NUM), .P_PTR_W(C_PTR_W)) u_pick (
    .req (i_s_axis_tvalid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < P_REQ_NUM; k++)
      if (pick_gnt[k]) pick_idx = C_PTR_W'(k);
  end

  assign sel_valid = i_s_axis_tvalid[g_idx];
  assign sel_last  = i_s_axis_tlast[g_idx];
  assign sel_user  = i_s_axis_tuser[g_idx];
  assign sel_data  = i_s_axis_tdata[32'(g_idx)*C_AXIS_DW +: C_AXIS_DW];
  assign sel_keep  = i_s_axis_tkeep[32'(g_idx)*C_AXIS_KW +: C_AXIS_KW];
  assign next_ptr  = (g_idx == C_LAST_REQ) ? '0 : g_idx + 1'b1;
  assign at_limit  = (beat_cnt == C_LAST_BEAT);
  assign start     = i_stat_rx_status && pick_vld;
  assign o_grant   = grant;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;

  // Truncation forces tlast+tuser on the limit beat only when the source has not ended itself.
  always_comb begin
    state_nxt       = state;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tdata  = '0;
    o_m_axis_tkeep  = '0;
    o_m_axis_tlast  = 1'b0;
    o_m_axis_tuser  = 1'b0;
    o_s_axis_tready = '0;
    trunc           = 1'b0;
    eff_last        = 1'b0;
    accept          = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_XFER;
      ST_XFER: begin
        trunc           = at_limit && !sel_last;
        eff_last        = sel_last || at_limit;
        o_m_axis_tvalid = sel_valid;
        o_m_axis_tdata  = sel_data;
        o_m_axis_tkeep  = sel_keep;
        o_m_axis_tlast  = eff_last;
        o_m_axis_tuser  = sel_user || trunc;
        o_s_axis_tready = grant & {P_REQ_NUM{i_m_axis_tready}};
        accept          = sel_valid && i_m_axis_tready;
        if (accept && eff_last) state_nxt = trunc ? ST_DROP : ST_IDLE;
      end
      ST_DROP: begin
        o_s_axis_tready = grant;
        if (sel_valid && sel_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant       <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      o_pkt_cnt   <= '0;
      o_trunc_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          grant    <= pick_gnt;
          g_idx    <= pick_idx;
          beat_cnt <= '0;
        end
        ST_XFER: if (accept) begin
          if (eff_last) begin
            o_pkt_cnt <= o_pkt_cnt + 1'b1;
            if (trunc) begin
              o_trunc_cnt <= o_trunc_cnt + 1'b1;
            end else begin
              rr_ptr <= next_ptr;
              grant  <= '0;
            end
          end else if (!at_limit) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DROP: if (sel_valid && sel_last) begin
          rr_ptr <= next_ptr;
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_up_link_tx_arbiter.sv
// Directed, table-driven bench for up_link_tx_arbiter (4 requesters, 8-beat limit).
module tb_up_link_tx_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          link;
  logic [N-1:0]  s_tvalid, s_tlast, s_tuser, s_tready;
  logic [N*64-1:0] s_tdata;
  logic [N*8-1:0]  s_tkeep;
  logic          m_tvalid, m_tlast, m_tuser, m_tready;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [N-1:0]  grant;
  logic [31:0]   pkt_cnt, trunc_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  up_link_tx_arbiter #(.P_REQ_NUM(4), .P_MAX_BEATS(8), .P_CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stat_rx_status(link),
    .i_s_axis_tvalid(s_tvalid), .i_s_axis_tdata(s_tdata), .i_s_axis_tkeep(s_tkeep),
    .i_s_axis_tlast(s_tlast), .i_s_axis_tuser(s_tuser), .o_s_axis_tready(s_tready),
    .o_m_axis_tvalid(m_tvalid), .o_m_axis_tdata(m_tdata), .o_m_axis_tkeep(m_tkeep),
    .o_m_axis_tlast(m_tlast), .o_m_axis_tuser(m_tuser), .i_m_axis_tready(m_tready),
    .o_grant(grant), .o_pkt_cnt(pkt_cnt), .o_trunc_cnt(trunc_cnt)
  );

  typedef struct {
    logic       rst_n, link, mrdy;
    logic [3:0] vld, last, user;
    int         seq;
    logic       e_mvld, e_mlast, e_muser;
    logic [3:0] e_grant, e_srdy;
    int         e_pkt, e_trunc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] lane_data(input int k, input int sq);
    return {8'(8'hA0 + k), 8'(sq), 48'h0123_4567_89AB};
  endfunction

  task automatic add(input int rn, lk, vld, lst, usr, sq, mr,
                     ev, eg, es, el, eu, ep, et);
    vec_t v;
    v.rst_n = rn[0]; v.link = lk[0]; v.vld = vld[3:0]; v.last = lst[3:0];
    v.user = usr[3:0]; v.seq = sq; v.mrdy = mr[0];
    v.e_mvld = ev[0]; v.e_grant = eg[3:0]; v.e_srdy = es[3:0];
    v.e_mlast = el[0]; v.e_muser = eu[0]; v.e_pkt = ep; v.e_trunc = et;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int gi;
    @(negedge clk);
    rst_n = v.rst_n; link = v.link; m_tready = v.mrdy;
    s_tvalid = v.vld; s_tlast = v.last; s_tuser = v.user;
    for (int k = 0; k < N; k++) begin
      s_tdata[k*64 +: 64] = lane_data(k, v.seq);
      s_tkeep[k*8 +: 8]   = v.last[k] ? 8'h0F : 8'hFF;
    end
    #1;
    vectors++;
    gi = 0;
    for (int k = 0; k < N; k++) if (v.e_grant[k]) gi = k;
    chk("m_tvalid", 64'(m_tvalid), 64'(v.e_mvld));
    chk("grant",    64'(grant),    64'(v.e_grant));
    chk("s_tready", 64'(s_tready), 64'(v.e_srdy));
    chk("m_tlast",  64'(m_tlast),  64'(v.e_mlast));
    chk("m_tuser",  64'(m_tuser),  64'(v.e_muser));
    chk("pkt_cnt",  64'(pkt_cnt),  64'(v.e_pkt));
    chk("trunc_cnt",64'(trunc_cnt),64'(v.e_trunc));
    if (v.e_mvld) begin
      chk("m_tdata", m_tdata, lane_data(gi, v.seq));
      chk("m_tkeep", 64'(m_tkeep), v.last[gi] ? 64'h0F : 64'hFF);
    end
    if (!v.rst_n) begin
      chk("rst_tdata", m_tdata, 64'h0);
      chk("rst_tkeep", 64'(m_tkeep), 64'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; link = 1'b0; m_tready = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;

    // rst, link, vld, last, user, seq, mrdy | mvld, grant, srdy, mlast, muser, pkt, trunc
    // single requester, 3 beats, tuser passthrough on beat 2, tkeep 0F on last
    add(1,1,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    add(1,1,'b0001,'b0000,'b0000,1,1, 1,'b0001,'b0001,0,0, 0,0);
    add(1,1,'b0001,'b0000,'b0001,2,1, 1,'b0001,'b0001,0,1, 0,0);
    add(1,1,'b0001,'b0001,'b0000,3,1, 1,'b0001,'b0001,1,0, 0,0);
    add(1,1,'b0000,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 1,0);
    // reset, then all four requesters with 2-beat packets: 0,1,2,3,0
    add(0,1,'b1111,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    add(1,1,'b1111,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    for (int k = 0; k < 5; k++) begin
      add(1,1,'b1111,'b0000,        'b0000,1,1, 1,1<<(k%4),1<<(k%4),0,0, k,0);
      add(1,1,'b1111,1<<(k%4),      'b0000,2,1, 1,1<<(k%4),1<<(k%4),1,0, k,0);
      add(1,1,'b1111,'b0000,        'b0000,0,1, 0,'b0000,'b0000,0,0, k+1,0);
    end
    // requester 1 granted from the previous idle cycle; MAC tready toggles
    add(1,1,'b0010,'b0000,'b0000,1,1, 1,'b0010,'b0010,0,0, 5,0);
    add(1,1,'b0010,'b0000,'b0000,2,0, 1,'b0010,'b0000,0,0, 5,0);
    add(1,1,'b0010,'b0000,'b0000,2,1, 1,'b0010,'b0010,0,0, 5,0);
    add(1,1,'b0010,'b0010,'b0000,3,0, 1,'b0010,'b0000,1,0, 5,0);
    add(1,1,'b0010,'b0010,'b0000,3,1, 1,'b0010,'b0010,1,0, 5,0);
    add(1,1,'b0000,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 6,0);
    // reset, then requester 1 sends 12 beats: truncated at 8, 9..12 dropped
    add(0,1,'b0000,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    add(1,1,'b0010,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    for (int b = 1; b <= 7; b++)
      add(1,1,'b0010,'b0000,'b0000,b,1, 1,'b0010,'b0010,0,0, 0,0);
    add(1,1,'b0010,'b0000,'b0000,8,1, 1,'b0010,'b0010,1,1, 0,0);
    for (int b = 9; b <= 11; b++)
      add(1,1,'b0010,'b0000,'b0000,b,1, 0,'b0010,'b0010,0,0, 1,1);
    add(1,1,'b0010,'b0010,'b0000,12,1, 0,'b0010,'b0010,0,0, 1,1);
    // next grant goes to requester 2; single-beat packet
    add(1,1,'b0111,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 1,1);
    add(1,1,'b0111,'b0100,'b0000,1,1, 1,'b0100,'b0100,1,0, 1,1);
    // exactly 8 beats with tlast on the limit beat: normal end, no truncation
    add(1,1,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 2,1);
    for (int b = 1; b <= 7; b++)
      add(1,1,'b0001,'b0000,'b0000,b,1, 1,'b0001,'b0001,0,0, 2,1);
    add(1,1,'b0001,'b0001,'b0000,8,1, 1,'b0001,'b0001,1,0, 2,1);
    add(1,1,'b0000,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 3,1);
    // link down blocks grants; raising it grants next edge; mid-packet drop completes
    add(1,0,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 3,1);
    add(1,0,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 3,1);
    add(1,1,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 3,1);
    add(1,1,'b0001,'b0000,'b0000,1,1, 1,'b0001,'b0001,0,0, 3,1);
    add(1,0,'b0001,'b0000,'b0000,2,1, 1,'b0001,'b0001,0,0, 3,1);
    add(1,0,'b0001,'b0001,'b0000,3,1, 1,'b0001,'b0001,1,0, 3,1);
    add(1,0,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 4,1);
    add(1,0,'b0001,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 4,1);
    // reset mid-XFER of requester 1; afterwards arbitration restarts at requester 0
    add(1,1,'b0011,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 4,1);
    add(1,1,'b0011,'b0000,'b0000,1,1, 1,'b0010,'b0010,0,0, 4,1);
    add(0,1,'b0011,'b0000,'b0000,2,1, 0,'b0000,'b0000,0,0, 0,0);
    add(1,1,'b0011,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 0,0);
    add(1,1,'b0011,'b0000,'b0000,1,1, 1,'b0001,'b0001,0,0, 0,0);
    add(1,1,'b0011,'b0001,'b0000,2,1, 1,'b0001,'b0001,1,0, 0,0);
    add(1,1,'b0000,'b0000,'b0000,0,1, 0,'b0000,'b0000,0,0, 1,0);

    // power-on reset state
    #2;
    vectors++;
    chk("por_mvld",  64'(m_tvalid), 64'h0);
    chk("por_grant", 64'(grant),    64'h0);
    chk("por_srdy",  64'(s_tready), 64'h0);
    chk("por_pkt",   64'(pkt_cnt),  64'h0);
    chk("por_trunc", 64'(trunc_cnt),64'h0);

    foreach (tbl[i]) apply_vec(tbl[i]);

    // asynchronous reset asserted between clock edges during a transfer
    @(negedge clk);
    s_tvalid = 4'b0100; s_tlast = '0; s_tuser = '0; link = 1'b1; m_tready = 1'b1;
    @(negedge clk); #1;
    vectors++;
    chk("pre_async_grant", 64'(grant),    64'h4);
    chk("pre_async_mvld",  64'(m_tvalid), 64'h1);
    chk("pre_async_pkt",   64'(pkt_cnt),  64'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    chk("async_grant", 64'(grant),    64'h0);
    chk("async_mvld",  64'(m_tvalid), 64'h0);
    chk("async_srdy",  64'(s_tready), 64'h0);
    chk("async_pkt",   64'(pkt_cnt),  64'h0);
    chk("async_tdata", m_tdata,       64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
